// File: rtl/noc_ni_bridge.sv
// Network interface on a router's local port: packetizes wide memory requests into
// AXI-Stream flits and reassembles response packets into single wide responses.
module noc_ni_bridge #(
    parameter int DX_W      = 2,
    parameter int DY_W      = 2,
    parameter int CUR_X     = 0,
    parameter int CUR_Y     = 0,
    parameter int TDATA_W   = 32,
    parameter int BEAT_N    = 4,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic                             req_we_i,
    input  logic [ADDR_W-1:0]                req_addr_i,
    input  logic [ID_W-1:0]                  req_id_i,
    input  logic [BEAT_N*TDATA_W-1:0]        req_wdata_i,
    input  logic [BEAT_N*TDATA_W/8-1:0]      req_wstrb_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic                             rsp_we_o,
    output logic [ID_W-1:0]                  rsp_id_o,
    output logic [BEAT_N*TDATA_W-1:0]        rsp_rdata_o,
    output logic                             rsp_err_o,
    output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt_o,
    output logic                             noc_req_tvalid_o,
    input  logic                             noc_req_tready_i,
    output logic [TDATA_W-1:0]               noc_req_tdata_o,
    output logic [TDATA_W/8-1:0]             noc_req_tstrb_o,
    output logic [TDATA_W/8-1:0]             noc_req_tkeep_o,
    output logic                             noc_req_tlast_o,
    output logic [ID_W-1:0]                  noc_req_tid_o,
    output logic [DY_W+DX_W-1:0]             noc_req_tdest_o,
    output logic [DY_W+DX_W:0]               noc_req_tuser_o,
    input  logic                             noc_rsp_tvalid_i,
    output logic                             noc_rsp_tready_o,
    input  logic [TDATA_W-1:0]               noc_rsp_tdata_i,
    input  logic [TDATA_W/8-1:0]             noc_rsp_tstrb_i,
    input  logic [TDATA_W/8-1:0]             noc_rsp_tkeep_i,
    input  logic                             noc_rsp_tlast_i,
    input  logic [ID_W-1:0]                  noc_rsp_tid_i,
    input  logic [DY_W+DX_W-1:0]             noc_rsp_tdest_i,
    input  logic [DY_W+DX_W:0]               noc_rsp_tuser_i
);
    localparam int DW  = DY_W + DX_W;
    localparam int SW  = TDATA_W / 8;
    localparam int BW  = $clog2(BEAT_N);
    localparam int RBW = BW + 1;
    localparam int CW  = $clog2(MAX_OUTST + 1);
    localparam logic [BW-1:0]  TX_LAST    = BW'(BEAT_N - 1);
    localparam logic [RBW-1:0] RX_FULL    = RBW'(BEAT_N);
    localparam logic [RBW-1:0] RX_LAST_RD = RBW'(BEAT_N - 1);
    localparam logic [CW-1:0]  MAX_CNT    = CW'(MAX_OUTST);
    localparam logic [DW-1:0]  SRC        = {DY_W'(CUR_Y), DX_W'(CUR_X)};

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA} tx_state_t;
    typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

    tx_state_t                  tx_state_q, tx_state_d;
    logic                       tx_we_q, tx_we_d;
    logic [ADDR_W-1:0]          tx_addr_q, tx_addr_d;
    logic [ID_W-1:0]            tx_id_q, tx_id_d;
    logic [BEAT_N*TDATA_W-1:0]  tx_wdata_q, tx_wdata_d;
    logic [BEAT_N*SW-1:0]       tx_wstrb_q, tx_wstrb_d;
    logic [BW-1:0]              tx_beat_q, tx_beat_d;

    rx_state_t                  rx_state_q, rx_state_d;
    logic [RBW-1:0]             rx_beat_q, rx_beat_d;
    logic [BEAT_N*TDATA_W-1:0]  rx_rdata_q, rx_rdata_d;
    logic [ID_W-1:0]            rx_id_q, rx_id_d;
    logic                       rx_we_q, rx_we_d;
    logic                       rx_err_q, rx_err_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic req_hs, tx_hs, rx_hs, rsp_hs, pkt_we;
    logic unused_rsp;

    assign req_ready_o      = !rst && (tx_state_q == TX_IDLE) && (cnt_q < MAX_CNT);
    assign req_hs           = req_valid_i && req_ready_o;
    assign noc_req_tvalid_o = (tx_state_q != TX_IDLE);
    assign tx_hs            = noc_req_tvalid_o && noc_req_tready_i;
    assign noc_req_tkeep_o  = {SW{noc_req_tvalid_o}};
    assign noc_req_tid_o    = tx_id_q;
    assign noc_req_tdest_o  = tx_addr_q[ADDR_W-1 -: DW];
    assign noc_req_tuser_o  = {SRC, tx_we_q};

    assign noc_rsp_tready_o = !rst && (rx_state_q == RX_COLLECT);
    assign rx_hs            = noc_rsp_tvalid_i && noc_rsp_tready_o;
    assign rsp_valid_o      = (rx_state_q == RX_HOLD);
    assign rsp_hs           = rsp_valid_o && rsp_ready_i;
    assign rsp_we_o         = rx_we_q;
    assign rsp_id_o         = rx_id_q;
    assign rsp_rdata_o      = rx_rdata_q;
    assign rsp_err_o        = rx_err_q;
    assign outst_cnt_o      = cnt_q;
    assign unused_rsp       = ^{noc_rsp_tstrb_i, noc_rsp_tkeep_i, noc_rsp_tdest_i, noc_rsp_tuser_i[DW:1]};

    // Packet type is taken from the first flit; later flits reuse the latched copy.
    assign pkt_we = (rx_beat_q == '0) ? noc_rsp_tuser_i[0] : rx_we_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_we_d    = tx_we_q;
        tx_addr_d  = tx_addr_q;
        tx_id_d    = tx_id_q;
        tx_wdata_d = tx_wdata_q;
        tx_wstrb_d = tx_wstrb_q;
        tx_beat_d  = tx_beat_q;
        case (tx_state_q)
            TX_IDLE: if (req_hs) begin
                tx_we_d    = req_we_i;
                tx_addr_d  = req_addr_i;
                tx_id_d    = req_id_i;
                tx_wdata_d = req_wdata_i;
                tx_wstrb_d = req_wstrb_i;
                tx_beat_d  = '0;
                tx_state_d = TX_HDR;
            end
            TX_HDR: if (tx_hs) tx_state_d = tx_we_q ? TX_DATA : TX_IDLE;
            TX_DATA: if (tx_hs) begin
                if (tx_beat_q == TX_LAST) begin
                    tx_beat_d  = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_beat_d = tx_beat_q + BW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        noc_req_tdata_o = '0;
        noc_req_tstrb_o = '0;
        noc_req_tlast_o = 1'b0;
        if (tx_state_q == TX_HDR) begin
            noc_req_tdata_o = TDATA_W'(tx_addr_q);
            noc_req_tstrb_o = '1;
            noc_req_tlast_o = !tx_we_q;
        end else if (tx_state_q == TX_DATA) begin
            noc_req_tdata_o = tx_wdata_q[int'(tx_beat_q)*TDATA_W +: TDATA_W];
            noc_req_tstrb_o = tx_wstrb_q[int'(tx_beat_q)*SW +: SW];
            noc_req_tlast_o = (tx_beat_q == TX_LAST);
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_beat_d  = rx_beat_q;
        rx_rdata_d = rx_rdata_q;
        rx_id_d    = rx_id_q;
        rx_we_d    = rx_we_q;
        rx_err_d   = rx_err_q;
        case (rx_state_q)
            RX_COLLECT: if (rx_hs) begin
                if (rx_beat_q == '0) begin
                    rx_id_d = noc_rsp_tid_i;
                    rx_we_d = noc_rsp_tuser_i[0];
                end
                // Write acks carry no data; beats past BEAT_N are dropped.
                if (!pkt_we && rx_beat_q < RX_FULL)
                    rx_rdata_d[int'(rx_beat_q[BW-1:0])*TDATA_W +: TDATA_W] = noc_rsp_tdata_i;
                if (rx_beat_q != RX_FULL)
                    rx_beat_d = rx_beat_q + RBW'(1);
                if (noc_rsp_tlast_i) begin
                    rx_err_d   = (rx_beat_q != (pkt_we ? RBW'(0) : RX_LAST_RD)) || (cnt_q == '0);
                    rx_state_d = RX_HOLD;
                end
            end
            RX_HOLD: if (rsp_hs) begin
                rx_rdata_d = '0;
                rx_beat_d  = '0;
                rx_err_d   = 1'b0;
                rx_state_d = RX_COLLECT;
            end
            default: rx_state_d = RX_COLLECT;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req_hs && !(rsp_hs && cnt_q != '0))
            cnt_d = cnt_q + CW'(1);
        else if (!req_hs && rsp_hs && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_we_q    <= 1'b0;
            tx_addr_q  <= '0;
            tx_id_q    <= '0;
            tx_wdata_q <= '0;
            tx_wstrb_q <= '0;
            tx_beat_q  <= '0;
            rx_state_q <= RX_COLLECT;
            rx_beat_q  <= '0;
            rx_rdata_q <= '0;
            rx_id_q    <= '0;
            rx_we_q    <= 1'b0;
            rx_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_we_q    <= tx_we_d;
            tx_addr_q  <= tx_addr_d;
            tx_id_q    <= tx_id_d;
            tx_wdata_q <= tx_wdata_d;
            tx_wstrb_q <= tx_wstrb_d;
            tx_beat_q  <= tx_beat_d;
            rx_state_q <= rx_state_d;
            rx_beat_q  <= rx_beat_d;
            rx_rdata_q <= rx_rdata_d;
            rx_id_q    <= rx_id_d;
            rx_we_q    <= rx_we_d;
            rx_err_q   <= rx_err_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
